vector_output_serializer: RTL
=============================

VECTOR_OUTPUT_SERIALIZER -- requirements
Module: vector_output_serializer

Interface
REQ-001 The parameter VECTOR_SIZE SHALL default to 6 and set the number of elements per captured vector.
REQ-002 The parameter OUTPUT_WIDTH SHALL default to 8 and set the width in bits of each element and of each emitted byte.
REQ-003 The parameter FIFO_DEPTH SHALL default to 4 and set the number of vector entries buffered; it SHALL be a power of two and at least 2.
REQ-004 The design SHALL use one clock; reset is asynchronous and active-high, with ports named clock and reset.
REQ-005 Port clock SHALL be an input, 1 bit wide, and be the single rising-edge clock.
REQ-006 Port reset SHALL be an input, 1 bit wide, asynchronous and active-high.
REQ-007 Port vectorIn SHALL be an input, VECTOR_SIZE*OUTPUT_WIDTH bits wide, carrying the packed CPU output vector; element k occupies bits [k*OUTPUT_WIDTH +: OUTPUT_WIDTH].
REQ-008 Port vectorFlag SHALL be an input, 1 bit wide, meaning vectorIn is valid this cycle.
REQ-009 Port byteOut SHALL be an output, OUTPUT_WIDTH bits wide, carrying the current serialized element.
REQ-010 Port byteValid SHALL be an output, 1 bit wide, meaning byteOut is valid.
REQ-011 Port byteReady SHALL be an input, 1 bit wide, meaning the downstream accepts byteOut.
REQ-012 Port fifoFull SHALL be an output, 1 bit wide, asserted when the entry count equals FIFO_DEPTH.
REQ-013 Port busy SHALL be an output, 1 bit wide, asserted when the FSM is not IDLE or the FIFO is non-empty.
REQ-014 Port dropCount SHALL be an output, 16 bits wide, holding the number of dropped vectors (see Configuration).

Function
REQ-015 A vector SHALL be pushed at a rising edge where vectorFlag=1 and the registered count is less than FIFO_DEPTH; there is no same-cycle pop bypass.
REQ-016 A vectorFlag=1 cycle while count equals FIFO_DEPTH SHALL drop that vector and leave FIFO contents unchanged.
REQ-017 Each cycle with vectorFlag=1 SHALL be a separate capture; consecutive flag cycles push consecutive entries.
REQ-018 Read and write pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL range from 0 to FIFO_DEPTH.
REQ-019 The FSM SHALL have exactly two states, IDLE and SEND.
REQ-020 IDLE SHALL transition to SEND when count is nonzero, with the element index set to 0.
REQ-021 In SEND, byteValid SHALL be 1 and byteOut SHALL be element[index] of the head entry, combinationally from registered state.
REQ-022 A transfer SHALL occur when byteValid=1 and byteReady=1; the index SHALL then advance by 1.
REQ-023 On a transfer at index VECTOR_SIZE-1, the head entry SHALL pop and the index SHALL reset to 0.
REQ-024 After that pop the FSM SHALL stay in SEND if count after the pop is nonzero (no bubble), else go to IDLE.
REQ-025 byteOut and byteValid SHALL hold stable while byteValid=1 and byteReady=0.
REQ-026 Latency SHALL be as follows: with the FIFO empty and state IDLE, a push at edge N SHALL yield byteValid=1 at edge N+2, i.e. after the IDLE-to-SEND transition, carrying element 0.
REQ-027 A simultaneous push and pop in one cycle SHALL leave count unchanged and both SHALL take effect.
REQ-028 Element 0 (the least significant bits) SHALL be emitted first.

Reset
REQ-029 Asserting reset at any time, including mid-vector, SHALL force the following values: state IDLE, index 0, pointers and count 0, byteValid 0, byteOut 0, fifoFull 0, busy 0, dropCount 0.
REQ-030 A partially sent vector at reset SHALL be discarded and SHALL NOT resume.
REQ-031 FIFO storage SHALL NOT be required to be cleared by reset.

Configuration
REQ-032 With macro VECTOR_OUTPUT_DROP_COUNT_EN defined, dropCount SHALL increment by 1 per dropped vector and saturate at 16'hFFFF.
REQ-033 With VECTOR_OUTPUT_DROP_COUNT_EN undefined, dropCount SHALL be constant 0 and no counter register SHALL be synthesized.

Verification
REQ-034 The bench SHALL cover this single-vector case: reset, then one flag cycle with vectorIn=48'h060504030201 and byteReady=1 -> bytes 01,02,03,04,05,06 on six consecutive cycles, first one two edges after capture, then byteValid=0 and busy=0.
REQ-035 The bench SHALL cover backpressure: byteReady toggling 1,0,1,0 -> byteOut holds each value while byteReady=0; the sequence is unchanged and there are no duplicates.
REQ-036 The bench SHALL cover overflow: byteReady=0 and 5 flag cycles with vectors V0..V4 -> fifoFull=1 after the 4th; V4 dropped; dropCount=1 with the macro, 0 without; releasing byteReady yields V0..V3 only (24 bytes).
REQ-037 The bench SHALL cover back-to-back vectors: two consecutive flag cycles with byteReady=1 -> 12 bytes with no idle cycle between the vectors.
REQ-038 The bench SHALL cover simultaneous push and pop: count=4, a final-byte transfer and vectorFlag=1 in the same cycle -> the new vector is dropped (registered-count rule) and count becomes 3.
REQ-039 The bench SHALL cover reset mid-vector: reset asserted after the 3rd byte of 48'hAABBCCDDEEFF -> byteValid=0 immediately (asynchronous); after release, no further bytes until a new flag.

Source files
------------

// File: rtl/vector_output_serializer_if.sv
// Handshake bundle between a vector producer and the byte serializer.
// The producer side is "master", the serializer side is "slave".
interface vector_output_serializer_if #(
  parameter int VECTOR_SIZE  = 6,
  parameter int OUTPUT_WIDTH = 8
);
  logic [VECTOR_SIZE*OUTPUT_WIDTH-1:0] vectorIn;
  logic                                vectorFlag;
  logic [OUTPUT_WIDTH-1:0]             byteOut;
  logic                                byteValid;
  logic                                byteReady;
  logic                                fifoFull;
  logic                                busy;
  logic [15:0]                         dropCount;

  modport master (
    output vectorIn, vectorFlag, byteReady,
    input  byteOut, byteValid, fifoFull, busy, dropCount
  );

  modport slave (
    input  vectorIn, vectorFlag, byteReady,
    output byteOut, byteValid, fifoFull, busy, dropCount
  );
endinterface

// File: rtl/vector_output_serializer.sv
// Buffers whole output vectors in a small FIFO and streams them out element 0 first
// over a valid/ready byte port. Define VECTOR_OUTPUT_DROP_COUNT_EN to count dropped vectors.
module vector_output_serializer #(
  parameter int VECTOR_SIZE  = 6,
  parameter int OUTPUT_WIDTH = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input logic                         clock,
  input logic                         reset,
  vector_output_serializer_if.slave   bus
);

  localparam int VEC_W = VECTOR_SIZE * OUTPUT_WIDTH;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                  state, stateNext;
  logic [VEC_W-1:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wrPtr, rdPtr;
  logic [CNT_W-1:0]        count, countNext;
  logic [IDX_W-1:0]        idx, idxNext;
  logic                    push, pop;
  logic [OUTPUT_WIDTH-1:0] headElem [VECTOR_SIZE];

  // Admission uses the registered count only, so a pop cannot make room in the same cycle.
  assign push = bus.vectorFlag && (count < CNT_W'(FIFO_DEPTH));

  always_comb begin
    for (int k = 0; k < VECTOR_SIZE; k++) begin
      headElem[k] = mem[rdPtr][k*OUTPUT_WIDTH +: OUTPUT_WIDTH];
    end
  end

  always_comb begin
    stateNext     = state;
    idxNext       = idx;
    pop           = 1'b0;
    bus.byteValid = 1'b0;
    bus.byteOut   = '0;
    case (state)
      IDLE: begin
        idxNext = '0;
        if (count != '0) stateNext = SEND;
      end
      SEND: begin
        bus.byteValid = 1'b1;
        bus.byteOut   = headElem[idx];
        if (bus.byteReady) begin
          if (idx == IDX_W'(VECTOR_SIZE - 1)) begin
            pop     = 1'b1;
            idxNext = '0;
            // Stay in SEND when another entry remains so vectors go out back to back.
            if (count == CNT_W'(1) && !push) stateNext = IDLE;
          end else begin
            idxNext = idx + IDX_W'(1);
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    countNext = count;
    case ({push, pop})
      2'b10:   countNext = count + CNT_W'(1);
      2'b01:   countNext = count - CNT_W'(1);
      default: countNext = count;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= stateNext;
      idx   <= idxNext;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      count <= countNext;
    end
  end

  // Vector storage carries data only and is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (push) mem[wrPtr] <= bus.vectorIn;
  end

  assign bus.fifoFull = (count == CNT_W'(FIFO_DEPTH));
  assign bus.busy     = (state != IDLE) || (count != '0);

`ifdef VECTOR_OUTPUT_DROP_COUNT_EN
  logic [15:0] dropCnt;

  function automatic logic [15:0] satInc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dropCnt <= '0;
    end else if (bus.vectorFlag && !push) begin
      dropCnt <= satInc(dropCnt);
    end
  end

  assign bus.dropCount = dropCnt;
`else
  assign bus.dropCount = '0;
`endif

endmodule
